regfile_multiport: RTL and testbench



---
 rtl/regfile_multiport.sv | 110 +++++++++++
 tb/tb_regfile_multiport.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// ============================================================================
// Module   : regfile_multiport
// Brief    : N-read / M-write register file with busy scoreboard and
//            optional same-cycle write-to-read bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_multiport #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr
);

    localparam logic [ADDR_W:0]   c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] c_ZERO     = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_WR-1:0]   w_wr_ok;
    logic                w_alloc_ok;

    // Address names a real, writable register (not XZR, not out of range).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_NUM_REGS) && (a != c_ZERO);
    endfunction

    generate
        for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_ok
            assign w_wr_ok[j] = wr_en[j] && addr_ok(wr_addr[j*ADDR_W +: ADDR_W]);
        end
    endgenerate

    assign w_alloc_ok = alloc_en && addr_ok(alloc_addr);

    // Later ports are applied last, so the highest-index writer wins; the
    // alloc set comes after the write clears so a new producer supersedes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_ok[j]) begin
                    r_regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                    r_busy[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (w_alloc_ok) begin
                r_busy[alloc_addr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rdata;
            logic              w_rbusy;
            logic              w_hit;
            logic              w_alloc_hit;

            always_comb begin
                w_ra        = rd_addr[k*ADDR_W +: ADDR_W];
                w_rdata     = '0;
                w_rbusy     = 1'b0;
                w_hit       = 1'b0;
                w_alloc_hit = w_alloc_ok && (alloc_addr == w_ra);
                if (!reset && addr_ok(w_ra)) begin
                    w_rdata = r_regs[w_ra];
                    w_rbusy = r_busy[w_ra];
                    if (BYPASS != 0) begin
                        for (int j = 0; j < NUM_WR; j++) begin
                            if (w_wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == w_ra)) begin
                                w_rdata = wr_data[j*DATA_W +: DATA_W];
                                w_hit   = 1'b1;
                            end
                        end
                        if (w_hit && !w_alloc_hit) begin
                            w_rbusy = 1'b0;
                        end
                    end
                end
            end

            assign rd_data[k*DATA_W +: DATA_W] = w_rdata;
            assign rd_busy[k]                  = w_rbusy;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// ============================================================================
// Module   : tb_regfile_multiport
// Brief    : Self-checking bench for regfile_multiport, bypass and no-bypass
//            instances driven in parallel against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_multiport;

    localparam int DW  = 64;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;
    localparam int NWR = 2;
    localparam int ZR  = 31;
    localparam logic [DW-1:0] c_PAT = 64'h0000010204080001;

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data1, rd_data0;
    logic [NRD-1:0]    rd_busy1, rd_busy0;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
                        .ZERO_REG(ZR), .BYPASS(1)) dut1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_busy(rd_busy1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    regfile_multiport #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
                        .ZERO_REG(ZR), .BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_busy(rd_busy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    function automatic bit ok_addr(input int a);
        return (a < NR) && (a != ZR);
    endfunction

    function automatic int waddr(input int j);
        return int'(wr_addr[j*AW +: AW]);
    endfunction

    function automatic logic [DW-1:0] exp_data(input int k, input bit byp);
        int a;
        a = int'(rd_addr[k*AW +: AW]);
        if (reset || !ok_addr(a)) return '0;
        if (byp) begin
            for (int j = NWR - 1; j >= 0; j--) begin
                if (wr_en[j] && waddr(j) == a) return wr_data[j*DW +: DW];
            end
        end
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int k, input bit byp);
        int a;
        bit hit;
        a   = int'(rd_addr[k*AW +: AW]);
        hit = 1'b0;
        if (reset || !ok_addr(a)) return 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && waddr(j) == a) hit = 1'b1;
        end
        if (byp && hit && !(alloc_en && int'(alloc_addr) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference state: register contents and pending-producer flags.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && ok_addr(waddr(j))) begin
                    m_regs[waddr(j)] <= wr_data[j*DW +: DW];
                    m_busy[waddr(j)] <= 1'b0;
                end
            end
            if (alloc_en && ok_addr(int'(alloc_addr))) m_busy[alloc_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < NRD; k++) begin
                chk($sformatf("byp1.rd_data[%0d]", k), rd_data1[k*DW +: DW], exp_data(k, 1'b1));
                chk($sformatf("byp1.rd_busy[%0d]", k), DW'(rd_busy1[k]), DW'(exp_busy(k, 1'b1)));
                chk($sformatf("byp0.rd_data[%0d]", k), rd_data0[k*DW +: DW], exp_data(k, 1'b0));
                chk($sformatf("byp0.rd_busy[%0d]", k), DW'(rd_busy0[k]), DW'(exp_busy(k, 1'b0)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        alloc_en = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
        wr_en[j]             = 1'b1;
        wr_addr[j*AW +: AW]  = AW'(a);
        wr_data[j*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return AW'($urandom_range(0, 7));
        if (r == 6) return AW'(ZR);
        return AW'($urandom_range(0, NR - 1));
    endfunction

    task automatic rand_inputs();
        for (int j = 0; j < NWR; j++) begin
            wr_en[j]            = ($urandom_range(0, 2) != 0);
            wr_addr[j*AW +: AW] = rand_addr();
            wr_data[j*DW +: DW] = {$urandom, $urandom};
        end
        alloc_en   = ($urandom_range(0, 3) == 0);
        alloc_addr = rand_addr();
        for (int k = 0; k < NRD; k++) begin
            if ($urandom_range(0, 2) == 0)
                rd_addr[k*AW +: AW] = wr_addr[$urandom_range(0, NWR - 1)*AW +: AW];
            else
                rd_addr[k*AW +: AW] = rand_addr();
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; alloc_en = 1'b0; alloc_addr = '0;
        tick();
        started = 1'b1;

        // Reset after live writes/allocs; reset must also beat same-cycle enables.
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin rand_inputs(); tick(); end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin rand_inputs(); tick(); end
        reset = 1'b0;
        idle();
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < NRD; k++) set_rd(k, g * 4 + k);
            #2;
            for (int k = 0; k < NRD; k++) begin
                chk("reset data", rd_data1[k*DW +: DW], '0);
                chk("reset busy", DW'(rd_busy1[k]), '0);
            end
            tick();
        end

        // XZR ignores writes and allocs.
        set_wr(0, ZR, 64'hA0);
        for (int k = 0; k < NRD; k++) set_rd(k, ZR);
        tick();
        idle();
        alloc_en = 1'b1; alloc_addr = AW'(ZR);
        #2;
        for (int k = 0; k < NRD; k++) chk("xzr data", rd_data1[k*DW +: DW], '0);
        tick();
        idle();
        #2;
        for (int k = 0; k < NRD; k++) chk("xzr busy", DW'(rd_busy1[k]), '0);

        // Two ports hitting reg 5: port 1 wins.
        set_wr(0, 5, 64'h1111);
        set_wr(1, 5, 64'h2222);
        set_rd(0, 5);
        #2;
        chk("collide bypass", rd_data1[0 +: DW], 64'h2222);
        chk("collide nobypass old", rd_data0[0 +: DW], 64'h0);
        tick();
        idle();
        #2;
        chk("collide stored b1", rd_data1[0 +: DW], 64'h2222);
        chk("collide stored b0", rd_data0[0 +: DW], 64'h2222);

        // Bypass timing on reg 7.
        set_wr(0, 7, 64'h1234);
        tick();
        idle();
        set_wr(1, 7, 64'hDEAD);
        set_rd(0, 7);
        #2;
        chk("bypass same cycle", rd_data1[0 +: DW], 64'hDEAD);
        chk("nobypass old value", rd_data0[0 +: DW], 64'h1234);
        tick();
        idle();
        #2;
        chk("nobypass next cycle", rd_data0[0 +: DW], 64'hDEAD);

        // Scoreboard on reg 3.
        set_rd(0, 3);
        alloc_en = 1'b1; alloc_addr = AW'(3);
        tick();
        idle();
        #2;
        chk("alloc busy", DW'(rd_busy1[0]), 64'd1);
        set_wr(0, 3, 64'h55);
        #2;
        chk("write clears busy bypass", DW'(rd_busy1[0]), 64'd0);
        chk("write pending busy nobypass", DW'(rd_busy0[0]), 64'd1);
        tick();
        idle();
        #2;
        chk("busy cleared", DW'(rd_busy0[0]), 64'd0);
        chk("data 0x55", rd_data0[0 +: DW], 64'h55);
        set_wr(1, 3, 64'h66);
        alloc_en = 1'b1; alloc_addr = AW'(3);
        #2;
        chk("alloc+write busy held", DW'(rd_busy1[0]), 64'd0);
        tick();
        idle();
        #2;
        chk("alloc+write busy", DW'(rd_busy1[0]), 64'd1);
        chk("alloc+write data", rd_data0[0 +: DW], 64'h66);

        // Pattern fill of regs 0..30, alternating write ports.
        for (int i = 0; i < NR - 1; i++) begin
            idle();
            set_wr(i % 2, i, 64'(i) * c_PAT);
            tick();
        end
        idle();
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < NRD; k++) set_rd(k, (g * 4 + k * 9) % NR);
            #2;
            for (int k = 0; k < NRD; k++) begin
                int a;
                a = (g * 4 + k * 9) % NR;
                chk($sformatf("pattern reg %0d", a), rd_data0[k*DW +: DW],
                    (a == ZR) ? 64'h0 : 64'(a) * c_PAT);
            end
            tick();
        end

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            rand_inputs();
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
